window_gen_w3x3: RTL and testbench

//  Converts a raster-order 8-bit pixel stream into a 3x3 neighbourhood window.

---
 rtl/median_pkg.sv | 10 +
 rtl/window_gen_w3x3_if.sv | 27 ++
 rtl/line_buffer.sv | 26 ++
 rtl/window_gen_w3x3.sv | 98 +++++++++
 tb/tb_window_gen_w3x3.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/median_pkg.sv
// Shared constants and pixel type for the 3x3 window and median filter blocks.
package median_pkg;

  localparam int unsigned DATA_W_DEF     = 8;
  localparam int unsigned IMG_WIDTH_DEF  = 640;
  localparam int unsigned IMG_HEIGHT_DEF = 480;

  typedef logic [DATA_W_DEF-1:0] pix_t;

endpackage

// File: rtl/window_gen_w3x3_if.sv
// Pixel stream in, 3x3 window out. The master end is the window generator.
interface window_gen_w3x3_if import median_pkg::*; #(
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              iValid;
  logic              iSof;
  logic [DATA_W-1:0] iPixel;
  logic              oValid;
  logic              oLast;
  logic [DATA_W-1:0] oP11, oP12, oP13;
  logic [DATA_W-1:0] oP21, oP22, oP23;
  logic [DATA_W-1:0] oP31, oP32, oP33;

  modport master (
    input  iValid, iSof, iPixel,
    output oValid, oLast,
    output oP11, oP12, oP13, oP21, oP22, oP23, oP31, oP32, oP33
  );

  modport slave (
    output iValid, iSof, iPixel,
    input  oValid, oLast,
    input  oP11, oP12, oP13, oP21, oP22, oP23, oP31, oP32, oP33
  );

endinterface

// File: rtl/line_buffer.sv
// One line of pixel storage; combinational read-first so the old value is visible
// in the same cycle the new one is written.
module line_buffer import median_pkg::*; #(
  parameter int unsigned DEPTH = IMG_WIDTH_DEF,
  parameter int unsigned WIDTH = DATA_W_DEF,
  localparam int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic             iClk,
  input  logic             iWe,
  input  logic [AddrW-1:0] iAddr,
  input  logic [WIDTH-1:0] iWData,
  output logic [WIDTH-1:0] oRData
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign oRData = mem[iAddr];

  // Write port; contents are never cleared, readers gate stale data.
  always_ff @(posedge iClk) begin
    if (iWe) begin
      mem[iAddr] <= iWData;
    end
  end

endmodule

// File: rtl/window_gen_w3x3.sv
// Raster pixel stream to 3x3 neighbourhood window. Row 0 of the array is the oldest
// line, column 2 the newest pixel. One-cycle latency, one window per accepted pixel.
module window_gen_w3x3 import median_pkg::*; #(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input logic               iClk,
  input logic               iRst,
  window_gen_w3x3_if.master winIf
);

  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);

  logic [ColW-1:0]   colQ, colEff;
  logic [RowW-1:0]   rowQ, rowEff;
  logic [DATA_W-1:0] lb0Rd, lb1Rd;
  logic [DATA_W-1:0] winQ [3][3];
  logic              validQ, lastQ;
  logic              accept;

  // Start-of-frame forces this pixel to the origin, resyncing truncated frames.
  always_comb begin
    colEff = winIf.iSof ? '0 : colQ;
    rowEff = winIf.iSof ? '0 : rowQ;
    accept = winIf.iValid & ~iRst;
  end

  // lb0 holds the previous line, lb1 the one before; lb1 is fed from lb0's old value.
  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_W)) uLb0 (
    .iClk   (iClk),
    .iWe    (accept),
    .iAddr  (colEff),
    .iWData (winIf.iPixel),
    .oRData (lb0Rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_W)) uLb1 (
    .iClk   (iClk),
    .iWe    (accept),
    .iAddr  (colEff),
    .iWData (lb0Rd),
    .oRData (lb1Rd)
  );

  // Counters, window shift and registered valid/last flags.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      colQ   <= '0;
      rowQ   <= '0;
      validQ <= 1'b0;
      lastQ  <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          winQ[r][c] <= '0;
        end
      end
    end else begin
      validQ <= 1'b0;
      lastQ  <= 1'b0;
      if (winIf.iValid) begin
        for (int r = 0; r < 3; r++) begin
          winQ[r][0] <= winQ[r][1];
          winQ[r][1] <= winQ[r][2];
        end
        winQ[0][2] <= lb1Rd;
        winQ[1][2] <= lb0Rd;
        winQ[2][2] <= winIf.iPixel;
        // Columns 0/1 of a line never complete a window, so nothing straddles an edge.
        validQ <= (colEff >= ColW'(2)) && (rowEff >= RowW'(2));
        lastQ  <= (colEff == ColLast) && (rowEff == RowLast);
        if (colEff == ColLast) begin
          colQ <= '0;
          rowQ <= (rowEff == RowLast) ? '0 : rowEff + RowW'(1);
        end else begin
          colQ <= colEff + ColW'(1);
          rowQ <= rowEff;
        end
      end
    end
  end

  assign winIf.oValid = validQ;
  assign winIf.oLast  = lastQ;
  assign winIf.oP11   = winQ[0][0];
  assign winIf.oP12   = winQ[0][1];
  assign winIf.oP13   = winQ[0][2];
  assign winIf.oP21   = winQ[1][0];
  assign winIf.oP22   = winQ[1][1];
  assign winIf.oP23   = winQ[1][2];
  assign winIf.oP31   = winQ[2][0];
  assign winIf.oP32   = winQ[2][1];
  assign winIf.oP33   = winQ[2][2];

endmodule

// File: tb/tb_window_gen_w3x3.sv
// Scoreboard bench for window_gen_w3x3 on a 4x4 frame.
module tb_window_gen_w3x3;
  import median_pkg::*;

  localparam int unsigned W = 4;
  localparam int unsigned H = 4;

  logic iClk = 1'b0;
  logic iRst;

  always #5 iClk = ~iClk;

  window_gen_w3x3_if #(.DATA_W(8)) winIf ();

  window_gen_w3x3 #(.DATA_W(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .iClk  (iClk),
    .iRst  (iRst),
    .winIf (winIf)
  );

  typedef struct packed {
    logic [71:0] win;
    logic        last;
  } exp_t;

  exp_t expQ[$];
  exp_t e;
  int   nVec  = 0;
  int   nFail = 0;
  bit   monOn = 1'b0;
  bit   done  = 1'b0;
  logic accPrev, stallPrev;
  logic [71:0] prevWin;

  // Hand-computed windows of frame 1..16; offset frames add a constant to every pixel.
  int baseTbl [4][9] = '{
    '{1, 2, 3, 5, 6, 7, 9, 10, 11},
    '{2, 3, 4, 6, 7, 8, 10, 11, 12},
    '{5, 6, 7, 9, 10, 11, 13, 14, 15},
    '{6, 7, 8, 10, 11, 12, 14, 15, 16}
  };

  function automatic logic [71:0] curWin();
    return {winIf.oP11, winIf.oP12, winIf.oP13, winIf.oP21, winIf.oP22, winIf.oP23,
            winIf.oP31, winIf.oP32, winIf.oP33};
  endfunction

  function automatic void pushFrame(input int off);
    logic [71:0] w;
    exp_t x;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 9; j++) begin
        w[71-8*j -: 8] = 8'(baseTbl[k][j] + off);
      end
      x.win  = w;
      x.last = (k == 3);
      expQ.push_back(x);
    end
  endfunction

  task automatic sendPix(input int p, input bit sof);
    winIf.iValid = 1'b1;
    winIf.iSof   = sof;
    winIf.iPixel = 8'(p);
    @(posedge iClk);
    #1;
    winIf.iValid = 1'b0;
    winIf.iSof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic sendFrame(input int base, input bit sof, input int gap);
    for (int i = 0; i < 16; i++) begin
      sendPix(base + i, sof && (i == 0));
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic pulseReset();
    // Valid pixel held during reset must be ignored.
    winIf.iValid = 1'b1;
    winIf.iSof   = 1'b0;
    winIf.iPixel = 8'd99;
    iRst         = 1'b1;
    @(posedge iClk);
    #1;
    iRst         = 1'b0;
    winIf.iValid = 1'b0;
  endtask

  task automatic summary();
    if (!done) begin
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    end
  endtask

  // What the DUT saw at the last edge: an accepted pixel or a plain stall.
  always @(posedge iClk) begin
    accPrev   <= winIf.iValid && !iRst;
    stallPrev <= !winIf.iValid && !iRst;
  end

  // Monitor: pop and compare on every window, check hold on stall cycles.
  always @(negedge iClk) begin
    if (monOn) begin
      if (winIf.oValid) begin
        nVec++;
        if (!accPrev) begin
          nFail++;
          $display("FAIL valid_on_stall: oValid=1 after non-accepting edge, required 0");
        end
        nVec++;
        if (expQ.size() == 0) begin
          nFail++;
          $display("FAIL unexpected_window: got %h last=%b, required no window",
                   curWin(), winIf.oLast);
        end else begin
          e = expQ.pop_front();
          if (curWin() !== e.win || winIf.oLast !== e.last) begin
            nFail++;
            $display("FAIL window: got %h last=%b, required %h last=%b",
                     curWin(), winIf.oLast, e.win, e.last);
          end
        end
      end else if (stallPrev) begin
        nVec++;
        if (curWin() !== prevWin || winIf.oLast !== 1'b0) begin
          nFail++;
          $display("FAIL hold: got %h last=%b, required %h last=0",
                   curWin(), winIf.oLast, prevWin);
        end
      end
      prevWin = curWin();
    end
  end

  initial begin
    iRst         = 1'b1;
    winIf.iValid = 1'b0;
    winIf.iSof   = 1'b0;
    winIf.iPixel = '0;
    repeat (2) @(posedge iClk);
    #1;
    iRst  = 1'b0;
    monOn = 1'b1;

    @(negedge iClk);
    nVec++;
    if (winIf.oValid !== 1'b0 || winIf.oLast !== 1'b0 || curWin() !== 72'd0) begin
      nFail++;
      $display("FAIL reset_state: valid=%b last=%b win=%h, required 0/0/0",
               winIf.oValid, winIf.oLast, curWin());
    end
    #2;

    // Back-to-back frame with start-of-frame.
    pushFrame(0);
    sendFrame(1, 1'b1, 0);
    idle(2);

    // Two idle cycles after every pixel.
    pushFrame(0);
    sendFrame(1, 1'b1, 2);
    idle(2);

    // Two frames back-to-back; second relies on counter wrap.
    pushFrame(0);
    pushFrame(100);
    sendFrame(1, 1'b1, 0);
    sendFrame(101, 1'b0, 0);
    idle(2);

    // Reset after pixel 10, restart with start-of-frame.
    for (int i = 1; i <= 10; i++) sendPix(i, i == 1);
    pulseReset();
    pushFrame(0);
    sendFrame(1, 1'b1, 0);
    idle(2);

    // Reset after pixel 5, restart without start-of-frame.
    for (int i = 1; i <= 5; i++) sendPix(i, i == 1);
    pulseReset();
    idle(1);
    pushFrame(0);
    sendFrame(1, 1'b0, 0);
    idle(2);

    // Start-of-frame on pixel 7 truncates the running frame.
    for (int i = 1; i <= 6; i++) sendPix(i, i == 1);
    pushFrame(6);
    sendFrame(7, 1'b1, 0);
    idle(3);

    nVec++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("FAIL missing_windows: %0d outstanding, required 0", expQ.size());
    end
    monOn = 1'b0;
    summary();
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    nVec++;
    nFail++;
    $display("FAIL timeout: run did not complete, required completion");
    summary();
    $finish;
  end

endmodule
